// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the architectural PC, drives the PC mux op, issues
// single-outstanding instruction fetches and hands instructions to decode.
// Execute-stage redirects replace the PC. A fetch that is still in flight
// when a redirect arrives is marked stale and its response is discarded.
module fetch_sequencer #(
  parameter int                         MEMORY_ADDR_W = 32,
  parameter int                         PC_OP_W       = 2,
  parameter logic [MEMORY_ADDR_W-1:0]   RESET_PC      = '0,
  parameter logic [PC_OP_W-1:0]         PC_OP_SEQ     = PC_OP_W'(0),
  parameter logic [PC_OP_W-1:0]         PC_OP_JAL     = PC_OP_W'(1),
  parameter logic [PC_OP_W-1:0]         PC_OP_JALR    = PC_OP_W'(2),
  parameter logic [PC_OP_W-1:0]         PC_OP_BRANCH  = PC_OP_W'(3)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [PC_OP_W-1:0]       pc_op,
  output logic [MEMORY_ADDR_W-1:0] pc,
  input  logic [MEMORY_ADDR_W-1:0] next_pc,
  input  logic                     ex_valid,
  input  logic [PC_OP_W-1:0]       ex_op,
  input  logic                     ex_taken,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [MEMORY_ADDR_W-1:0] imem_addr,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [31:0]              if_instr,
  output logic [MEMORY_ADDR_W-1:0] if_pc,
  output logic                     err_misaligned
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [MEMORY_ADDR_W-1:0] pc_q, pc_d;
  logic                     drop_q, drop_d;
  logic                     if_valid_q, if_valid_d;
  logic [31:0]              if_instr_q, if_instr_d;
  logic [MEMORY_ADDR_W-1:0] if_pc_q, if_pc_d;
  logic                     err_q, err_d;
  logic                     redirect;
  logic                     misalign;

  // Redirect decode; HALT ignores execute entirely, so pc_op falls back to SEQ.
  always_comb begin
    redirect = ex_valid && (state_q != S_HALT) &&
               ((ex_op == PC_OP_JAL) || (ex_op == PC_OP_JALR) ||
                ((ex_op == PC_OP_BRANCH) && ex_taken));
    misalign = redirect && (next_pc[1:0] != 2'b00);
    pc_op    = redirect ? ex_op : PC_OP_SEQ;
  end

  // Next-state logic for the fetch FSM, PC, stale-response flag and decode slot.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    err_d      = misalign;
    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = next_pc;
          if (misalign) begin
            drop_d  = 1'b0;
            state_d = S_HALT;
          end else if (imem_req_ready) begin
            // The request for the old PC was accepted this cycle: its
            // response is stale and must be thrown away.
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = next_pc;
          if (misalign) begin
            drop_d  = 1'b0;
            state_d = S_HALT;
          end else if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            if_instr_d = imem_rsp_data;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A redirect flushes the held instruction even if decode takes it.
        if (redirect) begin
          pc_d       = next_pc;
          if_valid_d = 1'b0;
          state_d    = misalign ? S_HALT : S_REQ;
        end else if (if_ready) begin
          pc_d       = next_pc;
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: begin
        if_valid_d = 1'b0;
        state_d    = S_HALT;
      end
    endcase
  end

  // State registers; reset returns to a fresh fetch from RESET_PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      err_q      <= err_d;
    end
  end

  // Output mapping; no request is presented while reset is held.
  always_comb begin
    imem_req_valid = (state_q == S_REQ) && !rst;
    imem_addr      = pc_q;
    pc             = pc_q;
    if_valid       = if_valid_q;
    if_instr       = if_instr_q;
    if_pc          = if_pc_q;
    err_misaligned = err_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, decode backpressure,
// redirects while waiting and holding, misaligned halt, async reset, PC wrap.
module tb_fetch_sequencer;

  localparam logic [1:0] OP_SEQ    = 2'd0;
  localparam logic [1:0] OP_JAL    = 2'd1;
  localparam logic [1:0] OP_JALR   = 2'd2;
  localparam logic [1:0] OP_BRANCH = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_op;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        ex_valid;
  logic [1:0]  ex_op;
  logic        ex_taken;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        err;
  logic [31:0] tgt;

  // Second instance for the wrap-around case.
  logic [1:0]  w_pc_op;
  logic [31:0] w_pc;
  logic [31:0] w_next_pc;
  logic        w_ex_valid;
  logic [1:0]  w_ex_op;
  logic        w_ex_taken;
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_if_valid;
  logic        w_if_ready;
  logic [31:0] w_if_instr;
  logic [31:0] w_if_pc;
  logic        w_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // PC mux model: sequential adds 4, any redirect returns the scenario target.
  always_comb next_pc   = (pc_op == OP_SEQ) ? pc + 32'd4 : tgt;
  always_comb w_next_pc = w_pc + 32'd4;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .pc_op(pc_op), .pc(pc), .next_pc(next_pc),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_taken(ex_taken),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .err_misaligned(err)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .pc_op(w_pc_op), .pc(w_pc), .next_pc(w_next_pc),
    .ex_valid(w_ex_valid), .ex_op(w_ex_op), .ex_taken(w_ex_taken),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .if_valid(w_if_valid), .if_ready(w_if_ready), .if_instr(w_if_instr), .if_pc(w_if_pc),
    .err_misaligned(w_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_op = OP_SEQ; ex_taken = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; if_ready = 1'b0; tgt = '0;
    w_ex_valid = 1'b0; w_ex_op = OP_SEQ; w_ex_taken = 1'b0; w_req_ready = 1'b0;
    w_rsp_valid = 1'b0; w_rsp_data = 32'hCAFE_0001; w_if_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_req_valid", {31'b0, req_valid}, 32'h0);

    // Sequential fetch of 0
    rst = 1'b0; #1;
    check("seq0_req_valid", {31'b0, req_valid}, 32'h1);
    check("seq0_addr", addr, 32'h0);
    check("seq0_pc_op", {30'b0, pc_op}, {30'b0, OP_SEQ});
    req_ready = 1'b1; tick();
    req_ready = 1'b0;
    check("wait0_req_valid", {31'b0, req_valid}, 32'h0);
    rsp_valid = 1'b1; rsp_data = 32'hA000_0000; tick();
    rsp_valid = 1'b0;
    check("hold0_if_valid", {31'b0, if_valid}, 32'h1);
    check("hold0_if_pc", if_pc, 32'h0);
    check("hold0_if_instr", if_instr, 32'hA000_0000);
    if_ready = 1'b1; #1;
    check("hold0_pc_op", {30'b0, pc_op}, {30'b0, OP_SEQ});
    tick();
    if_ready = 1'b0;
    check("req4_if_valid", {31'b0, if_valid}, 32'h0);
    check("req4_addr", addr, 32'h4);
    check("req4_req_valid", {31'b0, req_valid}, 32'h1);

    // Fetch 4 then hold it under decode backpressure
    req_ready = 1'b1; tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hA000_0004; tick();
    rsp_valid = 1'b0;
    check("hold4_if_pc", if_pc, 32'h4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_if_valid", {31'b0, if_valid}, 32'h1);
      check("bp_if_instr", if_instr, 32'hA000_0004);
      check("bp_if_pc", if_pc, 32'h4);
      check("bp_req_valid", {31'b0, req_valid}, 32'h0);
      check("bp_pc", pc, 32'h4);
    end
    if_ready = 1'b1; tick();
    if_ready = 1'b0;
    check("req8_addr", addr, 32'h8);

    // Fetch 8 to completion
    req_ready = 1'b1; tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hA000_0008; tick();
    rsp_valid = 1'b0;
    check("hold8_if_pc", if_pc, 32'h8);
    check("hold8_if_instr", if_instr, 32'hA000_0008);
    if_ready = 1'b1; tick();
    if_ready = 1'b0;
    check("reqC_addr", addr, 32'hC);

    // JAL redirect while waiting on the fetch of 0xC
    req_ready = 1'b1; tick();
    req_ready = 1'b0;
    ex_valid = 1'b1; ex_op = OP_JAL; tgt = 32'h100; #1;
    check("jal_pc_op", {30'b0, pc_op}, {30'b0, OP_JAL});
    tick();
    ex_valid = 1'b0;
    check("jal_req_valid", {31'b0, req_valid}, 32'h0);
    check("jal_pc", pc, 32'h100);
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF; tick();
    rsp_valid = 1'b0;
    check("stale_if_valid", {31'b0, if_valid}, 32'h0);
    check("stale_req_valid", {31'b0, req_valid}, 32'h1);
    check("stale_addr", addr, 32'h100);
    req_ready = 1'b1; tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hA000_0100; tick();
    rsp_valid = 1'b0;
    check("hold100_if_valid", {31'b0, if_valid}, 32'h1);
    check("hold100_if_pc", if_pc, 32'h100);
    check("hold100_if_instr", if_instr, 32'hA000_0100);

    // Branch not taken in HOLD
    ex_valid = 1'b1; ex_op = OP_BRANCH; ex_taken = 1'b0; tgt = 32'h40; #1;
    check("bnt_pc_op", {30'b0, pc_op}, {30'b0, OP_SEQ});
    tick();
    check("bnt_if_valid", {31'b0, if_valid}, 32'h1);
    check("bnt_pc", pc, 32'h100);
    if_ready = 1'b1; tick();
    ex_valid = 1'b0; if_ready = 1'b0;
    check("bnt_next_if_valid", {31'b0, if_valid}, 32'h0);
    check("bnt_next_addr", addr, 32'h104);
    req_ready = 1'b1; tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hA000_0104; tick();
    rsp_valid = 1'b0;
    check("hold104_if_pc", if_pc, 32'h104);

    // Branch taken in HOLD overrides a simultaneous decode handshake
    ex_valid = 1'b1; ex_op = OP_BRANCH; ex_taken = 1'b1; tgt = 32'h40; if_ready = 1'b1; #1;
    check("bt_pc_op", {30'b0, pc_op}, {30'b0, OP_BRANCH});
    tick();
    ex_valid = 1'b0; ex_taken = 1'b0; if_ready = 1'b0;
    check("bt_if_valid", {31'b0, if_valid}, 32'h0);
    check("bt_addr", addr, 32'h40);
    check("bt_req_valid", {31'b0, req_valid}, 32'h1);

    // Misaligned JALR halts the sequencer
    ex_valid = 1'b1; ex_op = OP_JALR; tgt = 32'h102; #1;
    check("jalr_pc_op", {30'b0, pc_op}, {30'b0, OP_JALR});
    check("jalr_err_before", {31'b0, err}, 32'h0);
    tick();
    ex_valid = 1'b0;
    check("halt_err_pulse", {31'b0, err}, 32'h1);
    check("halt_req_valid", {31'b0, req_valid}, 32'h0);
    check("halt_pc", pc, 32'h102);
    tick();
    check("halt_err_clear", {31'b0, err}, 32'h0);
    ex_valid = 1'b1; ex_op = OP_JAL; tgt = 32'h200; req_ready = 1'b1; #1;
    check("halt_pc_op", {30'b0, pc_op}, {30'b0, OP_SEQ});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_idle_req", {31'b0, req_valid}, 32'h0);
      check("halt_idle_if_valid", {31'b0, if_valid}, 32'h0);
      check("halt_idle_pc", pc, 32'h102);
      check("halt_idle_err", {31'b0, err}, 32'h0);
    end
    ex_valid = 1'b0; req_ready = 1'b0;

    // Asynchronous reset mid-cycle recovers
    rst = 1'b1; #1;
    check("arst_pc", pc, 32'h0);
    check("arst_req_valid", {31'b0, req_valid}, 32'h0);
    tick();
    rst = 1'b0; #1;
    check("arst_req_after", {31'b0, req_valid}, 32'h1);
    check("arst_addr", addr, 32'h0);
    req_ready = 1'b1; tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hB000_0000; tick();
    rsp_valid = 1'b0;
    check("arst_if_pc", if_pc, 32'h0);
    check("arst_if_instr", if_instr, 32'hB000_0000);

    // PC wrap: FFFF_FFFC advances to 0
    check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    w_req_ready = 1'b1; tick();
    w_req_ready = 1'b0; w_rsp_valid = 1'b1; tick();
    w_rsp_valid = 1'b0;
    check("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_second_addr", w_addr, 32'h0);
    check("wrap_req_valid", {31'b0, w_req_valid}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequencing controller for the program-counter datapath: owns the architectural PC register and selects the PC mux operation each cycle.
- Consumes the mux's next_pc result, issues single-outstanding instruction-memory fetches, and presents fetched instructions to decode with a valid/ready handshake.
- Sits between the execute stage (redirects), the PC mux, instruction memory and decode.

Parameters:
- MEMORY_ADDR_W, 32, PC and fetch address width.
- PC_OP_W, 2, width of the PC mux op field.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_OP_SEQ, 2'b00, mux op for sequential fetch (pc+4). Must differ from `PC_OP_JAL, `PC_OP_JALR and `PC_OP_BRANCH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_op  out  PC_OP_W  op driven to the PC mux (combinational).
- pc  out  MEMORY_ADDR_W  current PC register, driven to the PC mux.
- next_pc  in  MEMORY_ADDR_W  mux result for the current pc_op.
- ex_valid  in  1  execute presents a control-flow instruction this cycle.
- ex_op  in  PC_OP_W  its op: JAL, JALR or BRANCH.
- ex_taken  in  1  branch outcome; ignored unless ex_op is BRANCH.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  MEMORY_ADDR_W  fetch address.
- imem_rsp_valid  in  1  response valid; exactly one per accepted request; may arrive 1+ cycles after acceptance.
- imem_rsp_data  in  32  fetched instruction.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts.
- if_instr  out  32  instruction.
- if_pc  out  MEMORY_ADDR_W  address of if_instr.
- err_misaligned  out  1  one-cycle pulse on a misaligned redirect target.

Behaviour:
- Reset: pc=RESET_PC, state=REQ, drop=0. Outputs if_valid=0, if_instr=0, if_pc=0, err_misaligned=0. imem_req_valid is asserted the first cycle after reset deasserts.
- redirect = ex_valid && (ex_op==JAL || ex_op==JALR || (ex_op==BRANCH && ex_taken)).
- pc_op = redirect ? ex_op : PC_OP_SEQ. This is combinational, so next_pc is valid in the same cycle.
- State REQ:
  - imem_req_valid=1, imem_addr=pc.
  - On imem_req_ready: go to WAIT.
- State WAIT:
  - On imem_rsp_valid with drop=0: register if_instr=imem_rsp_data, if_pc=pc, if_valid=1; go to HOLD.
  - On imem_rsp_valid with drop=1: discard the response, clear drop, go to REQ.
- State HOLD:
  - if_valid=1; if_instr and if_pc are held stable until the handshake.
  - On if_valid && if_ready && !redirect: pc<=next_pc (pc+4), if_valid<=0, go to REQ.
- Redirect handling, any state except HALT: pc<=next_pc.
  - REQ without handshake: stay in REQ; the new address appears next cycle.
  - REQ with the handshake in the same cycle, or WAIT: set drop=1, go to / stay in WAIT.
  - Redirect and imem_rsp_valid in the same WAIT cycle: the response is discarded and the state goes to REQ (drop stays 0).
  - HOLD: if_valid<=0, go to REQ. A redirect overrides a simultaneous decode handshake; decode flushes on redirect.
- Misaligned redirect: if a redirect has next_pc[1:0]!=0:
  - err_misaligned=1 for one cycle.
  - pc<=next_pc; go to HALT.
  - An outstanding response is still absorbed and discarded.
  - HALT issues no requests, keeps if_valid=0, and ignores ex_valid. It exits only on reset.
- At most one request is outstanding. imem_req_valid never drops before imem_req_ready unless a redirect occurs; the address is then updated.
- PC arithmetic wraps modulo 2^MEMORY_ADDR_W: pc=FFFF_FFFC advances to 0000_0000.
- Reset asserted mid-transaction aborts everything immediately. A late response after reset is not expected; memory is reset by the same reset.

Test Plan:
- Reset then fetch with ready=1 and 1-cycle response: addresses 0,4,8 requested; if_pc 0,4,8 in order; pc_op=PC_OP_SEQ throughout.
- Decode backpressure: if_ready=0 for 5 cycles in HOLD -> if_valid, if_instr, if_pc stable; no new request; pc unchanged.
- JAL redirect while WAIT (mux returns 0x100) -> drop set; the stale response is discarded with if_valid staying 0; next request is to 0x100.
- BRANCH with ex_taken=0 in HOLD -> no redirect; pc_op=PC_OP_SEQ; the stream continues sequentially. With ex_taken=1 (target 0x40) -> if_valid clears and the next request is to 0x40.
- JALR target 0x102 -> err_misaligned pulses once; state HALT; no further imem_req_valid; async rst restores pc=0 and fetching resumes.
- Wrap: RESET_PC=FFFF_FFFC -> second request address 0000_0000.
